// File: rtl/fetch_stage_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fetch_stage_if
// Bundles the three buses of the fetch stage:
//   imem_*      : synchronous instruction memory read port (data one cycle
//                 after the request cycle)
//   redirect_*  : PC change requests from execute, plus the misalignment pulse
//   dec_*       : {pc, instruction} hand-off to decode (valid/ready)
// Modports:
//   master : the fetch stage itself
//   slave  : the surrounding core / environment (memory, execute, decode)
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_misaligned;

    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output redirect_misaligned,
        output dec_valid, dec_instr, dec_pc,
        input  dec_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  redirect_misaligned,
        input  dec_valid, dec_instr, dec_pc,
        output dec_ready
    );
endinterface

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// fetch_stage
// RV32I instruction fetch front-end. Owns the fetch PC, issues word reads to
// a synchronous instruction memory, buffers returned words in a small queue
// and hands {pc, instruction} to decode over valid/ready. A redirect from
// execute flushes every fetched-but-unconsumed instruction and restarts
// fetching at the (word-aligned) target.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch_stage_if.master (imem, redirect and decode buses)
// Parameters:
//   RESET_PC    : first fetch address after reset (word aligned)
//   QUEUE_DEPTH : instruction queue entries, >= 2
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);

    logic [31:0]      fpc_q, fpc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic             squash_q, squash_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [31:0]      q_pc_q    [QUEUE_DEPTH];
    logic [31:0]      q_pc_d    [QUEUE_DEPTH];
    logic [31:0]      q_instr_q [QUEUE_DEPTH];
    logic [31:0]      q_instr_d [QUEUE_DEPTH];

    logic             dec_valid_s;
    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic             shift_s;
    logic [31:0]      level_s;
    logic [OCC_W-1:0] wr_idx_s;

    // Per-cycle handshake, push and issue decisions.
    always_comb begin
        // A redirect cycle hides the head so nothing stale is consumed.
        dec_valid_s = (occ_q != {OCC_W{1'b0}}) && !bus.redirect_valid;
        pop_s       = dec_valid_s && bus.dec_ready;
        push_s      = inflight_q && !squash_q && !bus.redirect_valid;
        // Occupancy once this cycle's response and pop have settled; a new
        // request is only sent when its response is guaranteed a free slot.
        level_s     = 32'(occ_q) + 32'(inflight_q) - 32'(pop_s);
        issue_s     = rst_n && !bus.redirect_valid && (level_s < 32'(QUEUE_DEPTH));
        // Entry 0 is the head. It is only overwritten by a shift or a push,
        // so dec_pc/dec_instr keep their last value when the queue drains.
        shift_s     = pop_s && (occ_q > OCC_W'(1));
        wr_idx_s    = pop_s ? (occ_q - OCC_W'(1)) : occ_q;
    end

    // Next-state for fetch PC, in-flight tracking, occupancy and queue storage.
    always_comb begin
        if (bus.redirect_valid) begin
            fpc_d = {bus.redirect_pc[31:2], 2'b00};
        end else if (issue_s) begin
            fpc_d = fpc_q + 32'd4;   // wraps FFFF_FFFC -> 0 naturally
        end else begin
            fpc_d = fpc_q;
        end

        inflight_d    = issue_s;
        inflight_pc_d = issue_s ? fpc_q : inflight_pc_q;
        // Marks a response that would arrive after a redirect. Requests are
        // blocked in the redirect cycle, so this only guards against a
        // request ever being allowed to leave alongside a redirect.
        squash_d      = bus.redirect_valid && issue_s;

        if (bus.redirect_valid) begin
            occ_d = {OCC_W{1'b0}};
        end else begin
            occ_d = occ_q + OCC_W'(push_s) - OCC_W'(pop_s);
        end

        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_pc_d[i]    = q_pc_q[i];
            q_instr_d[i] = q_instr_q[i];
        end
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
            q_pc_d[i]    = shift_s ? q_pc_q[i + 1]    : q_pc_q[i];
            q_instr_d[i] = shift_s ? q_instr_q[i + 1] : q_instr_q[i];
        end
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            q_pc_d[i]    = (push_s && (wr_idx_s == OCC_W'(i))) ? inflight_pc_q  : q_pc_d[i];
            q_instr_d[i] = (push_s && (wr_idx_s == OCC_W'(i))) ? bus.imem_rdata : q_instr_d[i];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q         <= {RESET_PC[31:2], 2'b00};
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            squash_q      <= 1'b0;
            occ_q         <= {OCC_W{1'b0}};
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc_q[i]    <= 32'h0000_0000;
                q_instr_q[i] <= 32'h0000_0000;
            end
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
            occ_q         <= occ_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc_q[i]    <= q_pc_d[i];
                q_instr_q[i] <= q_instr_d[i];
            end
        end
    end

    assign bus.imem_req            = issue_s;
    assign bus.imem_addr           = fpc_q;
    assign bus.redirect_misaligned = rst_n && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign bus.dec_valid           = dec_valid_s;
    assign bus.dec_pc              = q_pc_q[0];
    assign bus.dec_instr           = q_instr_q[0];

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage. The expected decode stream is a list of
// consecutive word addresses starting at the last redirect target (or the
// reset PC); the monitor pops one entry per accepted decode handshake.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC   (RESET_PC),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc    = 32'h0;
    logic [31:0] prev_instr = 32'h0;

    // Memory contents: a scramble of the address so PC and data differ.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decode stream: consecutive words from the aligned start.
    task automatic exp_load(input logic [31:0] start);
        logic [31:0] p;
        exp_q.delete();
        p = {start[31:2], 2'b00};
        repeat (64) begin
            exp_q.push_back({p, mem_f(p)});
            p = p + 32'd4;
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = tgt;
        exp_load(tgt);
    endtask

    task automatic drop_redirect();
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    // Synchronous instruction memory model.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? mem_f(bus.imem_addr) : 32'hDEAD_BEEF;
    end

    // Monitor: checks every accepted instruction against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.redirect_valid) begin
                chk("dec_valid_in_redirect", 32'(bus.dec_valid), 32'd0);
            end
            chk("misaligned", 32'(bus.redirect_misaligned),
                32'(bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)));
            if (bus.imem_req) begin
                chk("imem_addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            end
            if (prev_stall && bus.dec_valid) begin
                chk("hold_pc", bus.dec_pc, prev_pc);
                chk("hold_instr", bus.dec_instr, prev_instr);
            end
            if (bus.dec_valid && bus.dec_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got pc %h expected no instruction at %0t", bus.dec_pc, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dec_pc", bus.dec_pc, mon_e[63:32]);
                    chk("dec_instr", bus.dec_instr, mon_e[31:0]);
                end
            end
            prev_stall = bus.dec_valid && !bus.dec_ready;
            prev_pc    = bus.dec_pc;
            prev_instr = bus.dec_instr;
        end
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "timeout");
    end

    int          req_cnt;
    int          len;
    int          mode;
    int          sel;
    logic [31:0] tgt;

    // Stimulus: directed scenarios, then randomized phases.
    initial begin
        rst_n              = 1'b0;
        bus.dec_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_dec_pc", bus.dec_pc, 32'd0);
        chk("rst_dec_instr", bus.dec_instr, 32'd0);
        chk("rst_misaligned", 32'(bus.redirect_misaligned), 32'd0);

        // Reset release, streaming at full rate.
        exp_load(RESET_PC);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, RESET_PC);
        chk("first_valid", 32'(bus.dec_valid), 32'd0);
        @(negedge clk);
        chk("second_addr", bus.imem_addr, RESET_PC + 32'd4);
        chk("second_valid", 32'(bus.dec_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("stream_valid", 32'(bus.dec_valid), 32'd1);
            chk("stream_pc", bus.dec_pc, RESET_PC + 32'(4 * k));
        end

        // Mid-stream reset, then restart with decode stalled.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.dec_valid), 32'd0);
        chk("async_rst_req", 32'(bus.imem_req), 32'd0);
        bus.dec_ready = 1'b0;
        exp_load(RESET_PC);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_cnt += int'(bus.imem_req);
            if (k >= 2) begin
                chk("stall_valid", 32'(bus.dec_valid), 32'd1);
                chk("stall_pc", bus.dec_pc, RESET_PC);
                chk("stall_req", 32'(bus.imem_req), 32'd0);
            end
        end
        chk("stall_req_count", 32'(req_cnt), 32'd2);

        // Release: words arrive in order.
        @(posedge clk);
        #1 bus.dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("release_pc", bus.dec_pc, RESET_PC + 32'(4 * k));
        end

        // Fill the queue again, then redirect to 0x100.
        @(posedge clk);
        #1 bus.dec_ready = 1'b0;
        repeat (4) @(posedge clk);
        redirect(32'h0000_0100);
        bus.dec_ready = 1'b1;
        @(negedge clk);
        chk("redir_req_n", 32'(bus.imem_req), 32'd0);
        drop_redirect();
        @(negedge clk);
        chk("redir_req_n1", 32'(bus.imem_req), 32'd1);
        chk("redir_addr_n1", bus.imem_addr, 32'h0000_0100);
        chk("redir_valid_n1", 32'(bus.dec_valid), 32'd0);
        @(negedge clk);
        chk("redir_valid_n2", 32'(bus.dec_valid), 32'd0);
        @(negedge clk);
        chk("redir_valid_n3", 32'(bus.dec_valid), 32'd1);
        chk("redir_pc_n3", bus.dec_pc, 32'h0000_0100);

        // Misaligned redirect while streaming.
        repeat (3) @(negedge clk);
        redirect(32'h0000_0203);
        @(negedge clk);
        chk("misal_pulse", 32'(bus.redirect_misaligned), 32'd1);
        drop_redirect();
        @(negedge clk);
        chk("misal_clear", 32'(bus.redirect_misaligned), 32'd0);
        chk("misal_addr", bus.imem_addr, 32'h0000_0200);
        @(negedge clk);
        @(negedge clk);
        chk("misal_pc", bus.dec_pc, 32'h0000_0200);

        // Back-to-back redirects: the later one wins.
        redirect(32'h0000_0040);
        redirect(32'h0000_0080);
        drop_redirect();
        @(negedge clk);
        chk("b2b_addr", bus.imem_addr, 32'h0000_0080);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_valid", 32'(bus.dec_valid), 32'd1);
        chk("b2b_pc", bus.dec_pc, 32'h0000_0080);

        // Address wrap.
        redirect(32'hFFFF_FFF8);
        drop_redirect();
        @(negedge clk);
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr2", bus.imem_addr, 32'h0000_0000);
        repeat (4) @(negedge clk);

        // Randomized phases.
        for (int ph = 0; ph < 40; ph++) begin
            len  = 4 + int'($urandom_range(29, 0));
            mode = int'($urandom_range(2, 0));
            repeat (len) begin
                @(posedge clk);
                #1;
                bus.dec_ready = (mode == 0) ? 1'b1 :
                                (mode == 1) ? ($urandom_range(1, 0) == 32'd1) :
                                              ($urandom_range(5, 0) == 32'd0);
            end
            sel = int'($urandom_range(9, 0));
            if (sel == 0) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                exp_load(RESET_PC);
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end else begin
                tgt = $urandom;
                if ($urandom_range(3, 0) == 32'd0) begin
                    tgt = 32'hFFFF_FFF0 | $urandom_range(15, 0);
                end
                redirect(tgt);
                if (sel < 3) begin
                    redirect($urandom);
                end
                drop_redirect();
            end
        end

        // Liveness after the last phase.
        @(posedge clk);
        #1 bus.dec_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("final_valid", 32'(bus.dec_valid), 32'd1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
